dmem_arbiter: RTL and testbench

//  Arbitrates the single-port 256-byte data RAM between the CPU MEM stage and an external DMA/loader port.

---
 rtl/dmem_arbiter.sv | 81 ++++++++
 tb/tb_dmem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 256-byte data RAM between the CPU MEM stage and a DMA port,
// CPU first, with starvation-forced DMA ownership windows.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_DMA_RUN  = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_MemRead,
  input  logic        cpu_MemWrite,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [7:0]  dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_MemRead,
  output logic        ram_MemWrite,
  input  logic [7:0]  ram_rdata,
  output logic [15:0] conflict_cnt
);
  localparam logic [0:0] CPU_OWN = 1'b0;
  localparam logic [0:0] DMA_OWN = 1'b1;
  logic [0:0] state;
  logic [CNT_W-1:0] wait_cnt, run_cnt;
  logic cpu_act, dma_sel;
  always_comb begin
    cpu_act      = cpu_MemRead | cpu_MemWrite;
    dma_sel      = reset & dma_req & ((state == DMA_OWN) | ~cpu_act);
    dma_gnt      = dma_sel;
    cpu_stall    = dma_sel & cpu_act;
    cpu_rdata    = ram_rdata;
    ram_addr     = dma_sel ? dma_addr : cpu_addr;
    ram_wdata    = dma_sel ? dma_wdata : cpu_wdata;
    ram_MemWrite = reset & (dma_sel ? dma_we : cpu_MemWrite);
    // a simultaneous CPU read+write performs only the write
    ram_MemRead  = reset & (dma_sel ? ~dma_we : cpu_MemRead & ~cpu_MemWrite);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= CPU_OWN;
      wait_cnt     <= '0;
      run_cnt      <= '0;
      dma_rvalid   <= 1'b0;
      dma_rdata    <= '0;
      conflict_cnt <= '0;
    end else begin
      dma_rvalid <= dma_sel & ~dma_we;
      if (dma_sel & ~dma_we) dma_rdata <= ram_rdata;
      if (cpu_act & dma_req & (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
      if (state == CPU_OWN) begin
        if (cpu_act & dma_req) begin
          if (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            state    <= DMA_OWN;
            wait_cnt <= '0;
            run_cnt  <= '0;
          end else
            wait_cnt <= wait_cnt + 1'b1;
        end else
          wait_cnt <= '0;
      end else if (dma_req) begin
        if (run_cnt == CNT_W'(MAX_DMA_RUN - 1)) begin
          state   <= CPU_OWN;
          run_cnt <= '0;
        end else
          run_cnt <= run_cnt + 1'b1;
      end else begin
        state   <= CPU_OWN;
        run_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed stimulus against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
  localparam int STARVE = 4;
  localparam int RUN    = 8;
  logic clk = 0, reset = 0;
  logic cpu_MemRead = 0, cpu_MemWrite = 0, dma_req = 0, dma_we = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [7:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;
  logic cpu_stall, dma_gnt, dma_rvalid, ram_MemRead, ram_MemWrite;
  logic [15:0] conflict_cnt;
  logic [7:0] mem [256];
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_MemWrite) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_MemRead(ram_MemRead),
    .ram_MemWrite(ram_MemWrite), .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
  );
  int checks = 0, errors = 0;
  logic [7:0] shadow [256];
  bit m_dma = 0, e_rvalid = 0, m_gnt = 0, last_stall = 0, last_gnt = 0;
  int m_blocked = 0, m_beats = 0, e_conf = 0;
  logic [7:0] e_rdata = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one cycle: inputs are already set at the negedge; returns at the next negedge
  task automatic step();
    int owner;
    bit ca, rd, wr;
    logic [7:0] a, d;
    #1;
    ca = cpu_MemRead | cpu_MemWrite;
    owner = !reset ? 0 : m_dma ? (dma_req ? 2 : 1) : ca ? 1 : dma_req ? 2 : 0;
    if (owner == 1 && !ca) owner = 0;
    rd = owner == 2 ? !dma_we : owner == 1 ? (cpu_MemRead & !cpu_MemWrite) : 1'b0;
    wr = owner == 2 ? dma_we : owner == 1 ? cpu_MemWrite : 1'b0;
    a = owner == 2 ? dma_addr : cpu_addr;
    d = owner == 2 ? dma_wdata : cpu_wdata;
    chk("dma_gnt", dma_gnt, int'(owner == 2));
    chk("cpu_stall", cpu_stall, int'(owner == 2 && ca));
    chk("ram_MemRead", ram_MemRead, rd);
    chk("ram_MemWrite", ram_MemWrite, wr);
    if (rd || wr) chk("ram_addr", ram_addr, a);
    if (wr) chk("ram_wdata", ram_wdata, d);
    if (owner == 1 && rd) chk("cpu_rdata", cpu_rdata, shadow[a]);
    last_stall = cpu_stall;
    last_gnt = dma_gnt;
    m_gnt = owner == 2;
    if (!reset) begin
      m_dma = 0; m_blocked = 0; m_beats = 0; e_rvalid = 0; e_rdata = 0; e_conf = 0;
    end else begin
      e_rvalid = owner == 2 && !dma_we;
      if (e_rvalid) e_rdata = shadow[a];
      if (wr) shadow[a] = d;
      if (ca && dma_req && e_conf < 65535) e_conf++;
      if (!m_dma) begin
        if (ca && dma_req) begin
          m_blocked++;
          if (m_blocked == STARVE) begin m_dma = 1; m_blocked = 0; m_beats = 0; end
        end else m_blocked = 0;
      end else if (dma_req) begin
        m_beats++;
        if (m_beats == RUN) begin m_dma = 0; m_beats = 0; end
      end else begin
        m_dma = 0; m_beats = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("dma_rvalid", dma_rvalid, e_rvalid);
    chk("dma_rdata", dma_rdata, e_rdata);
    chk("conflict_cnt", conflict_cnt, e_conf);
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 0;
    step();
    reset = 1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 0; shadow[i] = 0; end
    @(negedge clk);
    do_reset();
    chk("reset_conflict", conflict_cnt, 0);
    chk("reset_rvalid", dma_rvalid, 0);
    // CPU store then load
    cpu_MemWrite = 1; cpu_addr = 8'h10; cpu_wdata = 8'h5A;
    step();
    cpu_MemWrite = 0; cpu_MemRead = 1;
    step();
    chk("t1_lw", cpu_rdata, 8'h5A);
    chk("t1_conflict", conflict_cnt, 0);
    // DMA write then read with CPU idle
    cpu_MemRead = 0;
    dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 8'hA5;
    step();
    chk("t2_gnt_w", last_gnt, 1);
    dma_we = 0;
    step();
    chk("t2_gnt_r", last_gnt, 1);
    chk("t2_rvalid", dma_rvalid, 1);
    chk("t2_rdata", dma_rdata, 8'hA5);
    dma_req = 0;
    step();
    chk("t2_rvalid_pulse", dma_rvalid, 0);
    // starvation windows: 4 blocked, 8 granted, repeating
    do_reset();
    cpu_MemRead = 1; cpu_addr = 8'h10; dma_req = 1; dma_we = 0; dma_addr = 8'h20;
    for (int i = 0; i < 24; i++) begin
      step();
      chk("t3_stall", last_stall, int'((i % 12) >= 4));
    end
    chk("t3_conflict", conflict_cnt, 24);
    // DMA drops after 3 window beats: CPU served that cycle
    do_reset();
    for (int i = 0; i < 7; i++) step();
    dma_req = 0;
    step();
    chk("t4_stall", last_stall, 0);
    chk("t4_gnt", last_gnt, 0);
    step();
    // reset in a DMA write window blocks the write
    do_reset();
    cpu_MemRead = 0; cpu_MemWrite = 1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
    step();
    cpu_MemWrite = 0; cpu_MemRead = 1; cpu_addr = 8'h40;
    dma_req = 1; dma_we = 1; dma_addr = 8'h30; dma_wdata = 8'hEE;
    for (int i = 0; i < 4; i++) step();
    reset = 0;
    step();
    chk("t5_rst_gnt", last_gnt, 0);
    reset = 1; dma_req = 0; cpu_addr = 8'h30;
    step();
    chk("t5_mem", cpu_rdata, 8'h11);
    chk("t5_rvalid", dma_rvalid, 0);
    chk("t5_stall", last_stall, 0);
    // conflict counter saturation
    do_reset();
    cpu_MemRead = 1; cpu_addr = 8'h10; dma_req = 1; dma_we = 0; dma_addr = 8'h20;
    for (int i = 0; i < 70000; i++) step();
    chk("t6_sat", conflict_cnt, 16'hFFFF);
    // randomized traffic
    dma_req = 0;
    for (int i = 0; i < 3000; i++) begin
      int k;
      if (!dma_req || m_gnt) begin
        dma_req = $urandom_range(0, 2) != 0;
        dma_we = 1'($urandom);
        dma_addr = 8'($urandom_range(0, 15));
        dma_wdata = 8'($urandom);
      end
      k = $urandom_range(0, 3);
      cpu_MemRead = k == 1 || k == 3;
      cpu_MemWrite = k == 2;
      cpu_addr = 8'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom);
      reset = $urandom_range(0, 99) != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
